// File: rtl/sram_ctrl_if.sv
// Request bus between the SRAM front-end and sram_ctrl.
// The front-end drives the master side, sram_ctrl is the slave.
interface sram_ctrl_if;
    logic        stb;
    logic [19:0] addra;
    logic [47:0] dina;
    logic        we;
    logic [47:0] douta;
    logic        ack;

    modport master (
        output stb, addra, dina, we,
        input  douta, ack
    );

    modport slave (
        input  stb, addra, dina, we,
        output douta, ack
    );
endinterface

// File: rtl/sram_ctrl.sv
// Timed single-word access engine for the external 48-bit async SRAM.
// Optional read-data hold register: define SRAM_CTRL_RDATA_HOLD_EN.
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk50,
    input  logic        rst,
    sram_ctrl_if.slave  bus,
    output logic [19:0] sram_addr,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [47:0] sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [47:0] sram_dq_i
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_M1 = 4'(WAIT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       we_q, we_d;
    logic       accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.stb) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = WAIT_M1;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        we_d = accept ? bus.we : we_q;
    end

    always_ff @(posedge clk50 or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pins are registered from the next state so they change on the same
    // edge as the state they belong to.
    always_ff @(posedge clk50 or negedge rst) begin
        if (!rst) begin
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            sram_addr  <= 20'd0;
            sram_dq_o  <= 48'd0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            bus.ack    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            we_q  <= we_d;
            if (accept) begin
                sram_addr <= bus.addra;
                sram_dq_o <= bus.dina;
            end
            sram_ce_n  <= (state_d == IDLE);
            sram_oe_n  <= !(!we_d && (state_d == SETUP || state_d == ACCESS));
            sram_we_n  <= !(we_d && state_d == ACCESS);
            sram_dq_oe <= we_d && (state_d != IDLE);
            bus.ack    <= (state_d == DONE);
        end
    end

`ifdef SRAM_CTRL_RDATA_HOLD_EN
    logic [47:0] rdata_q;
    logic        rd_last;

    assign rd_last = (state_q == ACCESS) && (cnt_q == 4'd0) && !we_q;

    always_ff @(posedge clk50 or negedge rst) begin
        if (!rst) begin
            rdata_q <= 48'd0;
        end else if (rd_last) begin
            rdata_q <= sram_dq_i;
        end
    end

    assign bus.douta = rdata_q;
`else
    assign bus.douta = sram_dq_i;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed scoreboard bench for sram_ctrl (WAIT_CYCLES=2 and =1 instances)
// with a behavioral async SRAM model that keeps the last driven read value.
module tb_sram_ctrl;

    logic clk50 = 1'b0;
    logic rst;

    always #10 clk50 = ~clk50;

    sram_ctrl_if bus_a ();
    sram_ctrl_if bus_b ();

    logic [19:0] a_addr, b_addr;
    logic        a_ce_n, a_oe_n, a_we_n, a_dq_oe;
    logic        b_ce_n, b_oe_n, b_we_n, b_dq_oe;
    logic [47:0] a_dq_o, b_dq_o;
    logic [47:0] a_dq_i = 48'd0;
    logic [47:0] b_dq_i = 48'd0;

    sram_ctrl #(.WAIT_CYCLES(2)) dut_a (
        .clk50(clk50), .rst(rst), .bus(bus_a),
        .sram_addr(a_addr), .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n),
        .sram_we_n(a_we_n), .sram_dq_o(a_dq_o), .sram_dq_oe(a_dq_oe),
        .sram_dq_i(a_dq_i)
    );

    sram_ctrl #(.WAIT_CYCLES(1)) dut_b (
        .clk50(clk50), .rst(rst), .bus(bus_b),
        .sram_addr(b_addr), .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n),
        .sram_we_n(b_we_n), .sram_dq_o(b_dq_o), .sram_dq_oe(b_dq_oe),
        .sram_dq_i(b_dq_i)
    );

    typedef struct {
        logic [19:0] addr;
        logic        we;
        logic [47:0] data;
    } req_t;

    req_t        q_a[$];
    req_t        q_b[$];
    logic [47:0] mem [logic [19:0]];
    int          vec  = 0;
    int          miss = 0;

    function automatic logic [47:0] mem_rd(input logic [19:0] a);
        return mem.exists(a) ? mem[a] : 48'd0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SRAM model: write latched on rising we_n; read bus holds last value.
    always @(posedge a_we_n) if (a_ce_n === 1'b0 && a_dq_oe === 1'b1) mem[a_addr] = a_dq_o;
    always @(posedge b_we_n) if (b_ce_n === 1'b0 && b_dq_oe === 1'b1) mem[b_addr] = b_dq_o;
    always @(a_ce_n or a_oe_n or a_addr) if (a_ce_n === 1'b0 && a_oe_n === 1'b0) a_dq_i = mem_rd(a_addr);
    always @(b_ce_n or b_oe_n or b_addr) if (b_ce_n === 1'b0 && b_oe_n === 1'b0) b_dq_i = mem_rd(b_addr);

    task automatic sb_check(input string tag, input req_t r, input logic [47:0] douta);
        if (r.we) chk({tag, "_wr_mem"}, mem_rd(r.addr), r.data);
        else      chk({tag, "_rd_data"}, douta, r.data);
    endtask

    always @(negedge clk50) begin
        if (bus_a.ack === 1'b1) begin
            if (q_a.size() == 0) chk("a_ack_unexpected", 64'd1, 64'd0);
            else sb_check("a", q_a.pop_front(), bus_a.douta);
        end
        if (bus_b.ack === 1'b1) begin
            if (q_b.size() == 0) chk("b_ack_unexpected", 64'd1, 64'd0);
            else sb_check("b", q_b.pop_front(), bus_b.douta);
        end
    end

    int we_lo, oe_lo, ce_lo, dqoe_hi, acks, first_ack, addr_bad, overlap;

    task automatic observe(input bit b, input logic [19:0] exp_addr, input int n);
        logic ce, oe, we, dqoe, ack;
        logic [19:0] ad;
        we_lo = 0; oe_lo = 0; ce_lo = 0; dqoe_hi = 0;
        acks = 0; first_ack = -1; addr_bad = 0; overlap = 0;
        for (int i = 0; i < n; i++) begin
            ce   = b ? b_ce_n : a_ce_n;
            oe   = b ? b_oe_n : a_oe_n;
            we   = b ? b_we_n : a_we_n;
            dqoe = b ? b_dq_oe : a_dq_oe;
            ack  = b ? bus_b.ack : bus_a.ack;
            ad   = b ? b_addr : a_addr;
            if (!we) we_lo++;
            if (!oe) oe_lo++;
            if (dqoe) dqoe_hi++;
            if (!we && !oe) overlap++;
            if (!ce) begin
                ce_lo++;
                if (ad !== exp_addr) addr_bad++;
            end
            if (ack) begin
                acks++;
                if (first_ack < 0) first_ack = i;
            end
            @(negedge clk50);
        end
    endtask

    // Drives one request for a single cycle; returns at the negedge after E0.
    task automatic issue(input bit b, input logic [19:0] a, input bit w,
                         input logic [47:0] d, input logic [47:0] exp);
        req_t r;
        r.addr = a; r.we = w; r.data = exp;
        if (b) begin
            bus_b.stb = 1'b1; bus_b.addra = a; bus_b.we = w; bus_b.dina = d;
            q_b.push_back(r);
        end else begin
            bus_a.stb = 1'b1; bus_a.addra = a; bus_a.we = w; bus_a.dina = d;
            q_a.push_back(r);
        end
        @(negedge clk50);
        bus_a.stb = 1'b0;
        bus_b.stb = 1'b0;
    endtask

    function automatic logic [47:0] pat(input int i);
        return 48'h5A5A_0000_0000 ^ 48'(100 + i);
    endfunction

    initial begin
        int   n, last, gaps_bad, wl, ovl;
        req_t r;
        bus_a.stb = 1'b0; bus_a.addra = '0; bus_a.dina = '0; bus_a.we = 1'b0;
        bus_b.stb = 1'b0; bus_b.addra = '0; bus_b.dina = '0; bus_b.we = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk50);

        chk("rst_ce_n", a_ce_n, 1'b1);
        chk("rst_oe_n", a_oe_n, 1'b1);
        chk("rst_we_n", a_we_n, 1'b1);
        chk("rst_dq_oe", a_dq_oe, 1'b0);
        chk("rst_ack", bus_a.ack, 1'b0);
        chk("rst_addr", a_addr, 20'd0);
        chk("rst_dq_o", a_dq_o, 48'd0);
        chk("rst_b_ce_n", b_ce_n, 1'b1);
`ifdef SRAM_CTRL_RDATA_HOLD_EN
        chk("rst_douta", bus_a.douta, 48'd0);
`endif
        rst = 1'b1;
        @(negedge clk50);

        issue(0, 20'h80000, 1'b1, 48'h000008080000, 48'h000008080000);
        observe(0, 20'h80000, 8);
        chk("wr_we_lo", we_lo, 2);
        chk("wr_dqoe_hi", dqoe_hi, 4);
        chk("wr_ce_lo", ce_lo, 4);
        chk("wr_acks", acks, 1);
        chk("wr_ack_pos", first_ack, 3);
        chk("wr_addr_stable", addr_bad, 0);

        issue(0, 20'h80000, 1'b0, 48'd0, 48'h000008080000);
        observe(0, 20'h80000, 8);
        chk("rd_oe_lo", oe_lo, 3);
        chk("rd_dqoe_hi", dqoe_hi, 0);
        chk("rd_ack_pos", first_ack, 3);
`ifdef SRAM_CTRL_RDATA_HOLD_EN
        repeat (10) @(negedge clk50);
        chk("rd_hold", bus_a.douta, 48'h000008080000);
`endif

        // Held stb: front-end advances the address on each ack.
        r.addr = 20'd100; r.we = 1'b1; r.data = pat(0);
        bus_a.stb = 1'b1; bus_a.we = 1'b1; bus_a.addra = 20'd100; bus_a.dina = pat(0);
        q_a.push_back(r);
        n = 0; last = -1; gaps_bad = 0; wl = 0; ovl = 0;
        for (int c = 0; c < 80 && n < 8; c++) begin
            if (!a_we_n && !a_oe_n) ovl++;
            if (!a_we_n) wl++;
            if (bus_a.ack) begin
                if (last >= 0 && c - last != 5) gaps_bad++;
                last = c;
                n++;
                if (n < 8) begin
                    bus_a.addra = 20'(100 + n);
                    bus_a.dina  = pat(n);
                    r.addr = 20'(100 + n); r.data = pat(n);
                    q_a.push_back(r);
                end else begin
                    bus_a.stb = 1'b0;
                end
            end
            @(negedge clk50);
        end
        chk("held_acks", n, 8);
        chk("held_gaps", gaps_bad, 0);
        chk("held_we_lo", wl, 16);
        chk("held_overlap", ovl, 0);
        observe(0, 20'd0, 6);
        chk("held_no_extra_ack", acks, 0);
        chk("held_idle_ce", ce_lo, 0);

        issue(0, 20'd105, 1'b0, 48'd0, pat(5));
        observe(0, 20'd105, 8);
        chk("rb105_ack_pos", first_ack, 3);

        // stb dropped and inputs changed right after acceptance.
        issue(0, 20'd200, 1'b1, 48'hC0FFEE123456, 48'hC0FFEE123456);
        bus_a.addra = 20'h00001; bus_a.dina = 48'h111111111111; bus_a.we = 1'b0;
        observe(0, 20'd200, 8);
        chk("drop_acks", acks, 1);
        chk("drop_addr", addr_bad, 0);
        chk("drop_we_lo", we_lo, 2);
        chk("drop_mem1", mem_rd(20'h00001), 48'd0);

        // Reset in the middle of a write's ACCESS phase.
        issue(0, 20'd300, 1'b1, 48'h0BAD0BAD0BAD, 48'h0BAD0BAD0BAD);
        @(posedge clk50);
        #3;
        chk("pre_rst_we_n", a_we_n, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rst_we_n", a_we_n, 1'b1);
        chk("mid_rst_ce_n", a_ce_n, 1'b1);
        chk("mid_rst_oe_n", a_oe_n, 1'b1);
        chk("mid_rst_dq_oe", a_dq_oe, 1'b0);
        chk("mid_rst_ack", bus_a.ack, 1'b0);
        q_a.delete();
        @(negedge clk50);
        @(negedge clk50);
        rst = 1'b1;
        observe(0, 20'd0, 6);
        chk("post_rst_acks", acks, 0);
        chk("post_rst_idle", ce_lo, 0);
        issue(0, 20'h80000, 1'b0, 48'd0, 48'h000008080000);
        observe(0, 20'h80000, 8);
        chk("post_rst_rd_ack_pos", first_ack, 3);

        // WAIT_CYCLES=1 instance, top address.
        mem[20'hFFFFF] = 48'hABCDEF012345;
        issue(1, 20'hFFFFF, 1'b0, 48'd0, 48'hABCDEF012345);
        observe(1, 20'hFFFFF, 6);
        chk("w1_oe_lo", oe_lo, 2);
        chk("w1_ack_pos", first_ack, 2);
        chk("w1_acks", acks, 1);
        chk("w1_addr", addr_bad, 0);

        chk("sb_a_empty", q_a.size(), 0);
        chk("sb_b_empty", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
